// File: rtl/hamming_pkg.sv
// Shared types, data-position table and helper functions for the Hamming(15,11)+parity
// SECDED codeword format.
package hamming_pkg;

  typedef logic [15:0] codeword_t;
  typedef logic [10:0] data_t;
  typedef logic [3:0]  syndrome_t;

  // Hamming positions that carry data bits, LSB of the data word first.
  localparam int DATA_POS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  function automatic syndrome_t calc_syndrome(input codeword_t code);
    syndrome_t s;
    s = '0;
    for (int i = 1; i < 16; i++) begin
      if (code[i]) s = s ^ syndrome_t'(i);
    end
    return s;
  endfunction

  function automatic data_t extract_data(input codeword_t code);
    data_t d;
    for (int k = 0; k < 11; k++) begin
      d[k] = code[DATA_POS[k]];
    end
    return d;
  endfunction

  function automatic logic calc_overall_parity(input codeword_t code);
    return ^code;
  endfunction

endpackage

// File: rtl/hamming_secded_core.sv
// Combinational SECDED classification, single-bit correction and data extraction.
// Kept free of state so a memory scrubber can reuse it unchanged.
module hamming_secded_core
  import hamming_pkg::*;
(
  input  codeword_t code,
  input  syndrome_t syndrome,
  input  logic      parity,
  output data_t     data,
  output logic      corrected,
  output logic      uncorr
);

  codeword_t fixed;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    fixed     = code;
    corrected = 1'b0;
    uncorr    = 1'b0;
    if (parity) begin
      // Odd overall parity means one flipped bit; syndrome 0 points at the parity bit itself.
      fixed[syndrome] = ~code[syndrome];
      corrected       = 1'b1;
    end else if (syndrome != '0) begin
      uncorr = 1'b1;
    end
    data = extract_data(fixed);
  end

endmodule

// File: rtl/hamming_stream_decoder.sv
// Two-stage elastic SECDED decoder: stage 1 computes syndrome and parity, stage 2 holds the
// corrected word and status. Also keeps saturating corrected/uncorrectable counters.
module hamming_stream_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit DROP_UNCORR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_data,
  output logic             out_corrected,
  output logic             out_uncorr,
  output logic [3:0]       out_syndrome,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count
);

  logic      s1_v;
  codeword_t s1_code;
  syndrome_t s1_syn;
  logic      s1_par;

  logic      s2_v;
  logic      s2_drop;
  logic      s2_rdy;

  data_t     core_data;
  logic      core_corr;
  logic      core_uncorr;

  logic      corr_inc;
  logic      uncorr_inc;

  // A dropped uncorrectable word frees stage 2 on its own, whatever out_ready does.
  assign s2_drop   = DROP_UNCORR && s2_v && out_uncorr;
  assign s2_rdy    = !s2_v || out_ready || s2_drop;
  assign in_ready  = !s1_v || s2_rdy;
  assign out_valid = s2_v && !s2_drop;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
    end else if (in_ready) begin
      s1_v <= in_valid;
    end
  end

  // NOTE: the stage-1 datapath is not reset; s1_v alone decides whether its contents matter.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_code <= in_code;
      s1_syn  <= calc_syndrome(in_code);
      s1_par  <= calc_overall_parity(in_code);
    end
  end

  hamming_secded_core u_core (
    .code      (s1_code),
    .syndrome  (s1_syn),
    .parity    (s1_par),
    .data      (core_data),
    .corrected (core_corr),
    .uncorr    (core_uncorr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v          <= 1'b0;
      out_data      <= '0;
      out_corrected <= 1'b0;
      out_uncorr    <= 1'b0;
      out_syndrome  <= '0;
    end else if (s2_rdy) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_data      <= core_data;
        out_corrected <= core_corr;
        out_uncorr    <= core_uncorr;
        out_syndrome  <= s1_syn;
      end
    end
  end

  assign corr_inc   = out_valid && out_ready && out_corrected;
  assign uncorr_inc = s2_v && out_uncorr && (out_ready || s2_drop);

  // Clear has priority over a coincident increment; both counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else begin
      if (corr_inc && (corr_count != '1))
        corr_count <= corr_count + CNT_W'(1);
      if (uncorr_inc && (uncorr_count != '1))
        uncorr_count <= uncorr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Scoreboard bench for hamming_stream_decoder: three instances (default, DROP_UNCORR=1,
// CNT_W=2) share one stimulus stream; a monitor retires expected words per instance.
module tb_hamming_stream_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_code = '0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;

  logic        ir [3];
  logic        ov [3];
  logic        oc [3];
  logic        ou [3];
  logic [10:0] od [3];
  logic [3:0]  os [3];

  logic [15:0] cc_a, uc_a, cc_b, uc_b;
  logic [1:0]  cc_c, uc_c;

  always #5 clk = ~clk;

  hamming_stream_decoder u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_code(in_code),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_corrected(oc[0]),
    .out_uncorr(ou[0]), .out_syndrome(os[0]), .cnt_clr(cnt_clr),
    .corr_count(cc_a), .uncorr_count(uc_a)
  );

  hamming_stream_decoder #(.DROP_UNCORR(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_code(in_code),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_corrected(oc[1]),
    .out_uncorr(ou[1]), .out_syndrome(os[1]), .cnt_clr(cnt_clr),
    .corr_count(cc_b), .uncorr_count(uc_b)
  );

  hamming_stream_decoder #(.CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_code(in_code),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_corrected(oc[2]),
    .out_uncorr(ou[2]), .out_syndrome(os[2]), .cnt_clr(cnt_clr),
    .corr_count(cc_c), .uncorr_count(uc_c)
  );

  typedef struct {
    logic [10:0] d;
    logic        c;
    logic        u;
    logic [3:0]  s;
    int          acc;
    bit          lat;
  } item_t;

  item_t qa[$];
  item_t qb[$];
  item_t qc[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit saw_low = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int q_size(input int i);
    case (i)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic item_t q_front(input int i);
    case (i)
      0:       return qa[0];
      1:       return qb[0];
      default: return qc[0];
    endcase
  endfunction

  function automatic item_t q_pop(input int i);
    case (i)
      0:       return qa.pop_front();
      1:       return qb.pop_front();
      default: return qc.pop_front();
    endcase
  endfunction

  // Independent encoder: parity bits chosen so the XOR of set positions is zero.
  function automatic logic [15:0] enc(input logic [10:0] d);
    int          pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    logic [15:0] c = '0;
    logic [3:0]  s = '0;
    for (int k = 0; k < 11; k++) begin
      c[pos[k]] = d[k];
      if (d[k]) s = s ^ 4'(pos[k]);
    end
    c[1] = s[0];
    c[2] = s[1];
    c[4] = s[2];
    c[8] = s[3];
    c[0] = ^c[15:1];
    return c;
  endfunction

  // Present one word (caller is at a falling edge); push its expectation on acceptance.
  task automatic send(input logic [15:0] code, input logic [10:0] d, input logic c,
                      input logic u, input logic [3:0] s, input bit lat);
    int    w = 0;
    item_t it;
    in_valid = 1'b1;
    in_code  = code;
    #2;
    while (!ir[0] && w < 50) begin
      @(negedge clk);
      #2;
      w++;
    end
    if (!ir[0]) check("in_ready_timeout", 32'(ir[0]), 32'd1);
    it = '{d: d, c: c, u: u, s: s, acc: cyc, lat: lat};
    qa.push_back(it);
    qc.push_back(it);
    if (!u) qb.push_back(it);
    @(negedge clk);
  endtask

  task automatic drain();
    int w = 0;
    in_valid = 1'b0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: sampled 1 time unit before each rising edge.
  initial begin
    bit          stall [3];
    logic [16:0] hold [3];
    item_t       it;
    for (int i = 0; i < 3; i++) stall[i] = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          stall[i] = 1'b0;
        end else begin
          if (stall[i]) begin
            check("hold_valid", 32'(ov[i]), 32'd1);
            check("hold_stable", 32'({oc[i], ou[i], os[i], od[i]}), 32'(hold[i]));
          end
          if (ov[i]) begin
            if (q_size(i) == 0) begin
              check("unexpected_out", 32'(ov[i]), 32'd0);
            end else begin
              it = q_front(i);
              if (!stall[i] && it.lat) check("latency", 32'(cyc - it.acc), 32'd2);
              if (out_ready) begin
                it = q_pop(i);
                check("out_data", 32'(od[i]), 32'(it.d));
                check("out_flags", 32'({oc[i], ou[i]}), 32'({it.c, it.u}));
                check("out_syndrome", 32'(os[i]), 32'(it.s));
              end
            end
          end
          stall[i] = ov[i] && !out_ready;
          hold[i]  = {oc[i], ou[i], os[i], od[i]};
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [10:0] sd [8] = '{11'h001, 11'h2AA, 11'h555, 11'h7FF, 11'h123, 11'h400, 11'h0F0, 11'h30C};
    logic [10:0] cd [5] = '{11'h155, 11'h2AA, 11'h0F0, 11'h00F, 11'h700};
    logic [3:0]  cp [5] = '{4'd0, 4'd15, 4'd8, 4'd1, 4'd12};
    int          w;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_out_valid", 32'({ov[0], ov[1], ov[2]}), 32'd0);
    check("rst_out_data", 32'(od[0] | od[1] | od[2]), 32'd0);
    check("rst_flags_syn", 32'({oc[0], ou[0], os[0], oc[2], ou[2], os[2]}), 32'd0);
    check("rst_counters", 32'({cc_a, uc_a, cc_c, uc_c}), 32'd0);
    check("rst_in_ready", 32'({ir[0], ir[1], ir[2]}), 32'b111);
    @(negedge clk);

    // Clean words and latency.
    send(16'h0000, 11'h000, 1'b0, 1'b0, 4'h0, 1'b1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    send(16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'h0, 1'b1);
    drain();
    check("clean_corr_count", 32'(cc_a), 32'd0);

    // Single-bit errors: data bit and overall parity bit.
    send(16'hFFF7, 11'h7FF, 1'b1, 1'b0, 4'h3, 1'b1);
    drain();
    check("corr_count_1", 32'(cc_a), 32'd1);
    send(16'hFFFE, 11'h7FF, 1'b1, 1'b0, 4'h0, 1'b1);
    drain();
    check("corr_count_2", 32'(cc_a), 32'd2);
    check("corr_count_c_2", 32'(cc_c), 32'd2);

    // Double error: delivered by u_a/u_c, dropped by u_b.
    send(16'hFFF3, 11'h7FE, 1'b0, 1'b1, 4'h1, 1'b1);
    drain();
    check("uncorr_count_a", 32'(uc_a), 32'd1);
    check("uncorr_count_drop", 32'(uc_b), 32'd1);
    check("corr_count_b_kept", 32'(cc_b), 32'd2);

    // Back-to-back stream with a 3-cycle output stall.
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          if (k == 4) send(enc(sd[k]) ^ 16'h0040, sd[k], 1'b1, 1'b0, 4'd6, 1'b0);
          else        send(enc(sd[k]), sd[k], 1'b0, 1'b0, 4'd0, 1'b0);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          #3;
          if (!ir[0]) saw_low = 1'b1;
        end
      end
    join
    drain();
    check("in_ready_fell", 32'(saw_low), 32'd1);
    check("stream_corr_count", 32'(cc_a), 32'd3);

    // Clear, then saturation of the 2-bit counter.
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #2;
    check("clr_counters", 32'({cc_a, uc_a, uc_b, uc_c}), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++)
      send(enc(cd[k]) ^ (16'h0001 << cp[k]), cd[k], 1'b1, 1'b0, cp[k], 1'b0);
    drain();
    check("corr_count_a_5", 32'(cc_a), 32'd5);
    check("corr_count_c_sat", 32'(cc_c), 32'd3);

    // Clear coincident with a corrected retirement: clear wins.
    send(16'hFFF7, 11'h7FF, 1'b1, 1'b0, 4'h3, 1'b1);
    in_valid = 1'b0;
    w = 0;
    #2;
    while (!ov[0] && w < 10) begin
      @(negedge clk);
      #2;
      w++;
    end
    check("clr_wait_valid", 32'(ov[0]), 32'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    drain();
    check("clr_wins_a", 32'(cc_a), 32'd0);
    check("clr_wins_c", 32'(cc_c), 32'd0);

    // Reset with both stages full.
    send(16'hFFFE, 11'h7FF, 1'b1, 1'b0, 4'h0, 1'b0);
    drain();
    check("pre_rst_count", 32'(cc_a), 32'd1);
    out_ready = 1'b0;
    send(enc(11'h0AB), 11'h0AB, 1'b0, 1'b0, 4'h0, 1'b0);
    send(enc(11'h654), 11'h654, 1'b0, 1'b0, 4'h0, 1'b0);
    in_valid = 1'b0;
    #2;
    check("full_in_ready", 32'(ir[0]), 32'd0);
    check("full_out_valid", 32'(ov[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    qc.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #2;
    check("post_rst_valid", 32'({ov[0], ov[1], ov[2]}), 32'd0);
    check("post_rst_counts", 32'({cc_a, uc_a, cc_c}), 32'd0);
    check("post_rst_in_ready", 32'(ir[0]), 32'd1);
    @(negedge clk);
    send(enc(11'h3C3), 11'h3C3, 1'b0, 1'b0, 4'h0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
